// File: rtl/img_pkg.sv
// Shared image-pipeline constants and helpers used by the line buffer,
// window and kernel stages.
package img_pkg;

    // Default pixel depth in bits.
    localparam int unsigned IMG_DATA_WIDTH = 8;

    // Default number of pixels in one image line.
    localparam int unsigned IMG_LINE_WIDTH = 512;

    // Circular pointer increment: wraps from depth-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage : img_pkg

// File: rtl/line_buffer_ram.sv
// Generic simple dual-port RAM: one synchronous write port, one synchronous
// read port. A read and a write to the same address on the same edge return
// the old content (read-before-write). Contents are never reset so the array
// maps onto block RAM.
module line_buffer_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 512,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: store wr_data at wr_addr when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output, holds its value when rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end

endmodule : line_buffer_ram

// File: rtl/line_buffer.sv
// Single-line pixel store feeding the 3x3 window stage. Pixels written in
// raster order are replayed in the same order, one per read request, with
// one cycle of read latency. Write and read pointers wrap independently and
// no full/empty protection is provided; the upstream controller orders
// accesses.
module line_buffer
    import img_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = IMG_DATA_WIDTH,
    parameter int unsigned IMG_WIDTH  = IMG_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] inPixel,
    input  logic                  inPixelValid,
    input  logic                  outPixelReady,
    output logic [DATA_WIDTH-1:0] outPixel
);

    localparam int unsigned PTR_W = $clog2(IMG_WIDTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  out_zero_q, out_zero_d;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // Next-state pointer logic: advance on each strobe, wrap at the line end.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (inPixelValid) begin
            wr_ptr_d = PTR_W'(wrap_inc(int'(wr_ptr_q), IMG_WIDTH));
        end
        if (outPixelReady) begin
            rd_ptr_d = PTR_W'(wrap_inc(int'(rd_ptr_q), IMG_WIDTH));
        end
    end

    // Output-forcing flag: set by reset, cleared by the first read after it.
    always_comb begin
        out_zero_d = out_zero_q;
        if (outPixelReady) begin
            out_zero_d = 1'b0;
        end
    end

    // Pointer and flag registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_zero_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_zero_q <= out_zero_d;
        end
    end

    line_buffer_ram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (IMG_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (inPixelValid),
        .wr_addr (wr_ptr_q),
        .wr_data (inPixel),
        .rd_en   (outPixelReady),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // The RAM read register carries no reset so it stays block-RAM friendly;
    // the reset-to-zero of outPixel comes from out_zero_q, which is
    // asynchronously set and masks the RAM output until the next read lands.
    assign outPixel = out_zero_q ? '0 : ram_rd_data;

endmodule : line_buffer

// File: tb/tb_line_buffer.sv
// Self-checking bench for line_buffer: directed fill/drain, hold, overwrite,
// same-address read/write table, async reset mid-drain and a randomized
// phase checked against a queue-free array model of the line store.
module tb_line_buffer;

    localparam int unsigned DW = 8;
    localparam int unsigned W  = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] inPixel = '0;
    logic          inPixelValid = 1'b0;
    logic          outPixelReady = 1'b0;
    logic [DW-1:0] outPixel;

    always #5 clk = ~clk;

    line_buffer #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inPixel       (inPixel),
        .inPixelValid  (inPixelValid),
        .outPixelReady (outPixelReady),
        .outPixel      (outPixel)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: line contents, per-entry validity, write/read counts.
    logic [DW-1:0] m_mem [W];
    bit            m_vld [W];
    int unsigned   m_wc;
    int unsigned   m_rc;
    logic [DW-1:0] m_out;
    bit            m_known;

    typedef struct {
        bit            v;
        logic [DW-1:0] p;
        bit            r;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wc    = 0;
        m_rc    = 0;
        m_out   = '0;
        m_known = 1'b1;
        for (int i = 0; i < int'(W); i++) m_vld[i] = 1'b0;
    endtask

    // One clock: drive inputs, advance the model (read sees pre-write data),
    // then wait to 1 time unit after the edge.
    task automatic cycle(input bit v, input logic [DW-1:0] p, input bit r);
        inPixelValid  = v;
        inPixel       = p;
        outPixelReady = r;
        if (r) begin
            if (m_vld[m_rc]) begin
                m_out   = m_mem[m_rc];
                m_known = 1'b1;
            end else begin
                m_known = 1'b0;
            end
            m_rc = (m_rc + 1) % W;
        end
        if (v) begin
            m_mem[m_wc] = p;
            m_vld[m_wc] = 1'b1;
            m_wc = (m_wc + 1) % W;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        if (m_known) chk(name, 32'(outPixel), 32'(m_out));
    endtask

    task automatic do_reset();
        inPixelValid  = 1'b0;
        outPixelReady = 1'b0;
        inPixel       = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset_out", 32'(outPixel), 32'd0);
        chk("reset_wrptr", 32'(dut.wr_ptr_q), 32'd0);
        chk("reset_rdptr", 32'(dut.rd_ptr_q), 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        // Same-address read/write table; line preloaded with k^8'h5A, k=0 -> 8'h11.
        tbl[0] = '{v: 1'b1, p: 8'h22, r: 1'b1, exp: 8'h11}; // rd=wr=0: old data out
        tbl[1] = '{v: 1'b0, p: 8'h00, r: 1'b0, exp: 8'h11}; // idle: hold
        tbl[2] = '{v: 1'b1, p: 8'h33, r: 1'b0, exp: 8'h11}; // write addr1 only
        tbl[3] = '{v: 1'b0, p: 8'h00, r: 1'b1, exp: 8'h33}; // read addr1: new data
        tbl[4] = '{v: 1'b1, p: 8'h44, r: 1'b1, exp: 8'h58}; // rd=wr=2: old 2^5A
        tbl[5] = '{v: 1'b0, p: 8'h00, r: 1'b1, exp: 8'h59}; // addr3: 3^5A

        model_reset();
        @(posedge clk);
        #1;

        // Reset state and full-line fill/drain.
        do_reset();
        for (int i = 0; i < int'(W); i++) cycle(1'b1, DW'(i), 1'b0);
        for (int i = 0; i < int'(W); i++) begin
            cycle(1'b0, '0, 1'b1);
            chk("fill_drain", 32'(outPixel), 32'(i % 256));
        end
        chk("drain_rdptr_wrap", 32'(dut.rd_ptr_q), 32'd0);
        chk("fill_wrptr_wrap", 32'(dut.wr_ptr_q), 32'd0);

        // Hold while ready is low.
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
        chk("drain10", 32'(outPixel), 32'd9);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b0);
            chk("hold", 32'(outPixel), 32'd9);
        end
        cycle(1'b0, '0, 1'b1);
        chk("resume", 32'(outPixel), 32'd10);

        // Second line overwrites the first in place.
        do_reset();
        for (int i = 0; i < int'(W); i++) cycle(1'b1, DW'(i), 1'b0);
        for (int i = 0; i < int'(W); i++) cycle(1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < int'(W); i++) begin
            cycle(1'b0, '0, 1'b1);
            chk("overwrite", 32'(outPixel), 32'hAA);
        end

        // Simultaneous read/write at the same address.
        do_reset();
        for (int k = 0; k < int'(W); k++)
            cycle(1'b1, (k == 0) ? 8'h11 : DW'(k ^ 32'h5A), 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].v, tbl[i].p, tbl[i].r);
            chk($sformatf("rw_table[%0d]", i), 32'(outPixel), 32'(tbl[i].exp));
        end
        for (int k = 4; k < int'(W); k++) begin
            cycle(1'b0, '0, 1'b1);
            check_model("rw_tail");
        end
        cycle(1'b0, '0, 1'b1);
        chk("rw_addr0_new", 32'(outPixel), 32'h22);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        for (int i = 0; i < int'(W); i++) cycle(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, '0, 1'b1);
            check_model("predrain");
        end
        outPixelReady = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_out", 32'(outPixel), 32'd0);
        chk("async_rst_rdptr", 32'(dut.rd_ptr_q), 32'd0);
        chk("async_rst_wrptr", 32'(dut.wr_ptr_q), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, '0, 1'b1);
            check_model("post_rst_read");
        end

        // Randomized independent read/write traffic.
        do_reset();
        for (int i = 0; i < int'(W); i++) cycle(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 3000; i++) begin
            cycle(bit'($urandom_range(0, 1)), DW'($urandom), bit'($urandom_range(0, 1)));
            check_model("random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_line_buffer
